// File: rtl/carregador_pkg.sv
// Shared types and constants for the program loader.
package carregador_pkg;
  localparam int CP_W         = 8;
  localparam int LIMPA_PADRAO = 30;

  typedef enum logic [2:0] {
    ST_LIMPA,
    ST_ESPERA_TAM,
    ST_RECEBE,
    ST_CHECA,
    ST_FIM,
    ST_ERRO
  } estado_t;
endpackage

// File: rtl/carregador_programa.sv
// Program loader: clears low memory, streams a length-prefixed image into memory, then releases the CPU.
// Optional trailing checksum byte enabled by CARREGADOR_CHECKSUM_EN.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter logic [CP_W-1:0] BASE  = 8'h00,
  parameter int              LIMPA = LIMPA_PADRAO
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic [CP_W-1:0] DadoIn,
  input  logic            DadoValido,
  output logic            DadoPronto,
  output logic            EscMem,
  output logic [CP_W-1:0] Endereco,
  output logic [CP_W-1:0] ValorEscrito,
  output logic            Ocupado,
  output logic            CpuReset_n,
  output logic            Erro
);

`ifdef CARREGADOR_CHECKSUM_EN
  localparam estado_t ST_POS = ST_CHECA;
`else
  localparam estado_t ST_POS = ST_FIM;
`endif

  estado_t         st_q, st_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [CP_W-1:0] n_q, n_d, k_q, k_d;
  logic [CP_W-1:0] end_q, end_d, val_q, val_d;
  logic            esc_q, esc_d, pronto_q, pronto_d, ocup_q, ocup_d, cpu_q, cpu_d;
  logic            aceita;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [CP_W-1:0] soma_q, soma_d;
  logic            erro_q, erro_d;
`endif

  // DadoPronto is the registered handshake, so acceptance never depends on a same-cycle input path.
  assign aceita = DadoValido && pronto_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    n_d   = n_q;
    k_d   = k_q;
    end_d = end_q;
    val_d = val_q;
    esc_d = 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
    soma_d = soma_q;
`endif
    case (st_q)
      ST_LIMPA: begin
        if (LIMPA == 0) begin
          st_d = ST_ESPERA_TAM;
        end else begin
          esc_d = 1'b1;
          end_d = cnt_q[CP_W-1:0];
          val_d = '0;
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'(LIMPA - 1)) st_d = ST_ESPERA_TAM;
        end
      end
      ST_ESPERA_TAM: begin
        if (aceita) begin
          n_d = DadoIn;
          k_d = '0;
`ifdef CARREGADOR_CHECKSUM_EN
          soma_d = DadoIn;
`endif
          st_d = (DadoIn == '0) ? ST_POS : ST_RECEBE;
        end
      end
      ST_RECEBE: begin
        if (aceita) begin
          esc_d = 1'b1;
          end_d = BASE + k_q;
          val_d = DadoIn;
          k_d   = k_q + 8'd1;
`ifdef CARREGADOR_CHECKSUM_EN
          soma_d = soma_q + DadoIn;
`endif
          if (k_q == n_q - 8'd1) st_d = ST_POS;
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      ST_CHECA: begin
        if (aceita) st_d = (DadoIn == soma_q) ? ST_FIM : ST_ERRO;
      end
`endif
      default: ;
    endcase
    pronto_d = (st_d == ST_ESPERA_TAM) || (st_d == ST_RECEBE) || (st_d == ST_CHECA);
    // Handover lags the state by one edge so the last write cycle never overlaps the CPU.
    ocup_d = (st_q != ST_FIM);
    cpu_d  = (st_q == ST_FIM);
`ifdef CARREGADOR_CHECKSUM_EN
    erro_d = (st_q == ST_ERRO);
`endif
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q     <= ST_LIMPA;
      cnt_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      end_q    <= '0;
      val_q    <= '0;
      esc_q    <= 1'b0;
      pronto_q <= 1'b0;
      ocup_q   <= 1'b1;
      cpu_q    <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      soma_q   <= '0;
      erro_q   <= 1'b0;
`endif
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      k_q      <= k_d;
      end_q    <= end_d;
      val_q    <= val_d;
      esc_q    <= esc_d;
      pronto_q <= pronto_d;
      ocup_q   <= ocup_d;
      cpu_q    <= cpu_d;
`ifdef CARREGADOR_CHECKSUM_EN
      soma_q   <= soma_d;
      erro_q   <= erro_d;
`endif
    end
  end

  assign DadoPronto   = pronto_q;
  assign EscMem       = esc_q;
  assign Endereco     = end_q;
  assign ValorEscrito = val_q;
  assign Ocupado      = ocup_q;
  assign CpuReset_n   = cpu_q;
`ifdef CARREGADOR_CHECKSUM_EN
  assign Erro = erro_q;
`else
  assign Erro = 1'b0;
`endif

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: dut 0 has BASE=00/LIMPA=30, dut 1 has BASE=FE/LIMPA=0.
module tb_carregador_programa;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld[2];
  logic [7:0] din[2];
  logic       pronto[2], esc[2], ocup[2], cpurst[2], erro[2];
  logic [7:0] ende[2], val[2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  carregador_programa #(.BASE(8'h00), .LIMPA(30)) dut0 (
    .CLK(clk), .Reset_n(rst_n), .DadoIn(din[0]), .DadoValido(vld[0]),
    .DadoPronto(pronto[0]), .EscMem(esc[0]), .Endereco(ende[0]),
    .ValorEscrito(val[0]), .Ocupado(ocup[0]), .CpuReset_n(cpurst[0]), .Erro(erro[0]));

  carregador_programa #(.BASE(8'hFE), .LIMPA(0)) dut1 (
    .CLK(clk), .Reset_n(rst_n), .DadoIn(din[1]), .DadoValido(vld[1]),
    .DadoPronto(pronto[1]), .EscMem(esc[1]), .Endereco(ende[1]),
    .ValorEscrito(val[1]), .Ocupado(ocup[1]), .CpuReset_n(cpurst[1]), .Erro(erro[1]));

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int d, logic [7:0] b);
    vld[d] = 1'b1;
    din[d] = b;
    tick();
    vld[d] = 1'b0;
  endtask

  task automatic chk_wr(int d, string tag, logic [7:0] a, logic [7:0] v);
    check({tag, "_esc"}, {7'd0, esc[d]}, 8'd1);
    check({tag, "_addr"}, ende[d], a);
    check({tag, "_data"}, val[d], v);
  endtask

  task automatic chk_reset(int d, string tag);
    check({tag, "_esc"}, {7'd0, esc[d]}, 8'd0);
    check({tag, "_addr"}, ende[d], 8'h00);
    check({tag, "_data"}, val[d], 8'h00);
    check({tag, "_pronto"}, {7'd0, pronto[d]}, 8'd0);
    check({tag, "_ocup"}, {7'd0, ocup[d]}, 8'd1);
    check({tag, "_cpurst"}, {7'd0, cpurst[d]}, 8'd0);
    check({tag, "_erro"}, {7'd0, erro[d]}, 8'd0);
  endtask

  // Called right after the final accepted byte (program byte or checksum).
  task automatic end_ok(int d, string tag);
    check({tag, "_pronto_off"}, {7'd0, pronto[d]}, 8'd0);
    check({tag, "_ocup_hold"}, {7'd0, ocup[d]}, 8'd1);
    tick();
    check({tag, "_esc_off"}, {7'd0, esc[d]}, 8'd0);
    check({tag, "_ocup_rel"}, {7'd0, ocup[d]}, 8'd0);
    check({tag, "_cpurst_rel"}, {7'd0, cpurst[d]}, 8'd1);
    check({tag, "_erro"}, {7'd0, erro[d]}, 8'd0);
  endtask

  task automatic restart();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CARREGADOR_CHECKSUM_EN
  task automatic end_err(int d, string tag);
    check({tag, "_pronto_off"}, {7'd0, pronto[d]}, 8'd0);
    tick();
    check({tag, "_erro"}, {7'd0, erro[d]}, 8'd1);
    check({tag, "_ocup"}, {7'd0, ocup[d]}, 8'd1);
    check({tag, "_cpurst"}, {7'd0, cpurst[d]}, 8'd0);
    tick();
    check({tag, "_erro_hold"}, {7'd0, erro[d]}, 8'd1);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    din[0] = 8'h00; din[1] = 8'h00;
    tick(); tick();
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");

    // Clear phase, no stream.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_wr(0, $sformatf("clr%0d", i), 8'(i), 8'h00);
      if (i == 0) begin
        check("clr_pronto_first", {7'd0, pronto[0]}, 8'd0);
        check("l0_pronto", {7'd0, pronto[1]}, 8'd1);
        check("l0_esc", {7'd0, esc[1]}, 8'd0);
      end
    end
    tick();
    check("clr_done_esc", {7'd0, esc[0]}, 8'd0);
    check("clr_done_pronto", {7'd0, pronto[0]}, 8'd1);
    tick(); tick();
    check("idle_pronto", {7'd0, pronto[0]}, 8'd1);
    check("idle_cpurst", {7'd0, cpurst[0]}, 8'd0);
    check("idle_ocup", {7'd0, ocup[0]}, 8'd1);

    // Stream 03 AA BB 2F with a one-cycle gap.
    put(0, 8'h03);
    check("len_no_write", {7'd0, esc[0]}, 8'd0);
    put(0, 8'hAA);
    chk_wr(0, "p0", 8'h00, 8'hAA);
    tick();
    check("gap_esc", {7'd0, esc[0]}, 8'd0);
    check("gap_pronto", {7'd0, pronto[0]}, 8'd1);
    put(0, 8'hBB);
    chk_wr(0, "p1", 8'h01, 8'hBB);
    put(0, 8'h2F);
    chk_wr(0, "p2", 8'h02, 8'h2F);
`ifdef CARREGADOR_CHECKSUM_EN
    put(0, 8'h97);
    check("cs_no_write", {7'd0, esc[0]}, 8'd0);
`endif
    end_ok(0, "fim0");
    tick();
    check("fim0_hold", {7'd0, cpurst[0]}, 8'd1);

    // Address wrap on dut1.
    put(1, 8'h03);
    put(1, 8'h11);
    chk_wr(1, "w0", 8'hFE, 8'h11);
    put(1, 8'h22);
    chk_wr(1, "w1", 8'hFF, 8'h22);
    put(1, 8'h33);
    chk_wr(1, "w2", 8'h00, 8'h33);
`ifdef CARREGADOR_CHECKSUM_EN
    put(1, 8'h69);
`endif
    end_ok(1, "fim1");

    // Reset mid-load, with valid toggling while not ready.
    restart();
    for (int i = 0; i < 31; i++) tick();
    put(0, 8'h03);
    put(0, 8'h11);
    chk_wr(0, "ml0", 8'h00, 8'h11);
    put(0, 8'h22);
    chk_wr(0, "ml1", 8'h01, 8'h22);
    rst_n = 1'b0;
    #1;
    chk_reset(0, "abort");
    for (int i = 0; i < 4; i++) begin
      vld[0] = 1'($urandom_range(0, 1));
      din[0] = 8'($urandom);
      tick();
      check($sformatf("inrst_pronto%0d", i), {7'd0, pronto[0]}, 8'd0);
      check($sformatf("inrst_esc%0d", i), {7'd0, esc[0]}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      vld[0] = 1'($urandom_range(0, 1));
      din[0] = 8'($urandom);
      tick();
      chk_wr(0, $sformatf("reclr%0d", i), 8'(i), 8'h00);
    end
    vld[0] = 1'b0;
    tick();
    check("reclr_done_esc", {7'd0, esc[0]}, 8'd0);
    check("reclr_done_pronto", {7'd0, pronto[0]}, 8'd1);

    // Zero-length image.
    restart();
    tick();
    put(1, 8'h00);
    check("len0_esc", {7'd0, esc[1]}, 8'd0);
`ifdef CARREGADOR_CHECKSUM_EN
    check("len0_checa", {7'd0, pronto[1]}, 8'd1);
    put(1, 8'h00);
`endif
    end_ok(1, "len0");

`ifdef CARREGADOR_CHECKSUM_EN
    restart();
    tick();
    put(1, 8'h00);
    put(1, 8'h01);
    end_err(1, "len0_bad");

    restart();
    tick();
    put(1, 8'h02);
    put(1, 8'h10);
    chk_wr(1, "csok0", 8'hFE, 8'h10);
    put(1, 8'h20);
    chk_wr(1, "csok1", 8'hFF, 8'h20);
    put(1, 8'h32);
    end_ok(1, "csok");

    restart();
    tick();
    put(1, 8'h02);
    put(1, 8'h10);
    put(1, 8'h20);
    chk_wr(1, "csbad1", 8'hFF, 8'h20);
    put(1, 8'h31);
    end_err(1, "csbad");
`else
    check("erro_tied0", {7'd0, erro[0]}, 8'd0);
    check("erro_tied1", {7'd0, erro[1]}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
